// File: rtl/instr_loader.sv
// instr_loader: assembles a byte stream into 32-bit words and writes them
// to consecutive word addresses of the instruction RAM, holding the CPU in
// reset while the load is in progress.
module instr_loader #(
   parameter int MEM_SIZE = 1024,
   parameter int LEN_W    = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [LEN_W-1:0] num_words,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             wr_en,
   output logic [63:0]      wr_addr,
   output logic [31:0]      wr_data,
   output logic             busy,
   output logic             cpu_hold,
   output logic             done,
   output logic             error
);

   localparam logic [63:0] MEM_BYTES = 64'(MEM_SIZE);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_t;

   state_t           state, state_nx;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] wcnt_q;
   logic [1:0]       bcnt_q;
   logic [23:0]      asm_q;
   logic [63:0]      addr_q;

   // Byte length of the request, widened so the x4 never truncates.
   logic [LEN_W+1:0] req_bytes;
   logic             too_long;
   logic             can_start;
   logic             start_ok;
   logic             load_go;
   logic             accept;
   logic             last_word;

   assign req_bytes = {num_words, 2'b00};
   assign too_long  = {{(62-LEN_W){1'b0}}, req_bytes} > MEM_BYTES;
   assign can_start = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
   assign start_ok  = can_start && start;
   assign load_go   = start_ok && (num_words != '0) && !too_long;
   assign accept    = in_valid && in_ready;
   assign last_word = (wcnt_q + LEN_W'(1)) == len_q;
   assign cpu_hold  = busy;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nx;
   end

   // Next-state and per-state strobes.
   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      wr_en    = 1'b0;
      busy     = 1'b0;
      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               if (num_words == '0) state_nx = S_DONE;
               else if (too_long)   state_nx = S_ERR;
               else                 state_nx = S_RECV;
            end
         end
         S_RECV: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid && bcnt_q == 2'd3) state_nx = S_WRITE;
         end
         S_WRITE: begin
            wr_en    = 1'b1;
            busy     = 1'b1;
            state_nx = last_word ? S_DONE : S_RECV;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Datapath: byte assembly, address/word counters, status flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         len_q   <= '0;
         wcnt_q  <= '0;
         bcnt_q  <= '0;
         asm_q   <= '0;
         addr_q  <= '0;
         wr_addr <= '0;
         wr_data <= '0;
         done    <= 1'b0;
         error   <= 1'b0;
      end else begin
         if (start_ok) begin
            done  <= (num_words == '0);
            error <= (num_words != '0) && too_long;
         end
         if (load_go) begin
            len_q  <= num_words;
            wcnt_q <= '0;
            bcnt_q <= '0;
            addr_q <= '0;
         end
         if (accept) begin
            // MSB-first: earlier bytes end up in the upper bits of the word.
            asm_q  <= {asm_q[15:0], in_data};
            bcnt_q <= bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
               // Output registers are loaded here so they present the word
               // during WRITE and hold it afterwards.
               wr_data <= {asm_q, in_data};
               wr_addr <= addr_q;
            end
         end
         if (state == S_WRITE) begin
            addr_q <= addr_q + 64'd4;
            wcnt_q <= wcnt_q + LEN_W'(1);
            if (last_word) done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: table of loads checked against a queue-based reference
// model, plus hand sequences for reset abort and single-word timing.
module tb_instr_loader;
   localparam int MEM_SIZE = 1024;
   localparam int LEN_W    = 16;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             start = 1'b0;
   logic [LEN_W-1:0] num_words = '0;
   logic [7:0]       in_data = '0;
   logic             in_valid = 1'b0;
   logic             in_ready, wr_en, busy, cpu_hold, done, error;
   logic [63:0]      wr_addr;
   logic [31:0]      wr_data;

   instr_loader #(.MEM_SIZE(MEM_SIZE), .LEN_W(LEN_W)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .num_words(num_words),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
      .cpu_hold(cpu_hold), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [63:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t wq[$];
   int  viol = 0;

   // Write monitor: collects every write and flags in_ready during a write.
   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         wq.push_back('{wr_addr, wr_data});
         if (in_ready !== 1'b0) viol++;
      end
   end

   // Reference model: number of words actually written for a request.
   function automatic int model_nwrites(input int n);
      longint nb;
      nb = longint'(n) * 4;
      if (n == 0 || nb > MEM_SIZE) return 0;
      return n;
   endfunction

   typedef struct {
      int n;
      bit stall;
      bit poke;
      bit exp_done;
      bit exp_err;
   } vec_t;

   task automatic run_load(input vec_t v, input int k);
      logic [7:0] bq[$];
      int  nw, total, idx, cyc;
      bit  hs, poked, acc;
      nw    = model_nwrites(v.n);
      total = nw * 4;
      acc   = (nw != 0);
      for (int i = 0; i < total; i++) bq.push_back(8'($urandom));
      wq.delete();
      viol = 0;
      @(negedge clk);
      start = 1'b1;
      num_words = LEN_W'(v.n);
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("v%0d busy_after_start", k), 64'(busy), 64'(acc));
      chk($sformatf("v%0d ready_after_start", k), 64'(in_ready), 64'(acc));
      chk($sformatf("v%0d hold_after_start", k), 64'(cpu_hold), 64'(acc));
      if (acc) chk($sformatf("v%0d done_cleared", k), 64'(done), 64'd0);
      idx = 0;
      cyc = 0;
      poked = 1'b0;
      while (!(done === 1'b1 || error === 1'b1) && cyc < 5000) begin
         in_valid = (idx < total) && (!v.stall || $urandom_range(0, 2) != 0);
         if (in_valid) in_data = bq[idx];
         else          in_data = 8'h00;
         hs = in_valid && (in_ready === 1'b1);
         if (v.poke && !poked && idx == 2) begin
            start = 1'b1;
            num_words = LEN_W'(1);
            poked = 1'b1;
         end
         @(negedge clk);
         start = 1'b0;
         if (hs) idx++;
         cyc++;
      end
      in_valid = 1'b0;
      chk($sformatf("v%0d no_timeout", k), 64'(cyc < 5000), 64'd1);
      chk($sformatf("v%0d done", k), 64'(done), 64'(v.exp_done));
      chk($sformatf("v%0d error", k), 64'(error), 64'(v.exp_err));
      chk($sformatf("v%0d busy_end", k), 64'(busy), 64'd0);
      chk($sformatf("v%0d bytes_consumed", k), 64'(idx), 64'(total));
      chk($sformatf("v%0d nwrites", k), 64'(wq.size()), 64'(nw));
      chk($sformatf("v%0d ready_in_write", k), 64'(viol), 64'd0);
      for (int i = 0; i < nw && i < wq.size(); i++) begin
         chk($sformatf("v%0d w%0d addr", k, i), wq[i].addr, 64'(i * 4));
         chk($sformatf("v%0d w%0d data", k, i), 64'(wq[i].data),
             64'({bq[4*i], bq[4*i+1], bq[4*i+2], bq[4*i+3]}));
      end
   endtask

   vec_t vecs[9];

   initial begin
      logic [7:0] sb[4];
      vecs[0] = '{1,     0, 0, 1, 0};
      vecs[1] = '{3,     1, 0, 1, 0};
      vecs[2] = '{0,     0, 0, 1, 0};
      vecs[3] = '{2,     1, 0, 1, 0};
      vecs[4] = '{257,   0, 0, 0, 1};
      vecs[5] = '{16384, 0, 0, 0, 1};
      vecs[6] = '{256,   1, 0, 1, 0};
      vecs[7] = '{2,     1, 1, 1, 0};
      vecs[8] = '{5,     1, 0, 1, 0};
      sb[0] = 8'h91; sb[1] = 8'h00; sb[2] = 8'h04; sb[3] = 8'h21;

      // Reset state.
      #12;
      chk("rst in_ready", 64'(in_ready), 64'd0);
      chk("rst wr_en", 64'(wr_en), 64'd0);
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst done", 64'(done), 64'd0);
      chk("rst error", 64'(error), 64'd0);
      chk("rst wr_addr", wr_addr, 64'd0);
      chk("rst wr_data", 64'(wr_data), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Single word, back-to-back bytes, exact timing.
      wq.delete();
      @(negedge clk);
      start = 1'b1;
      num_words = LEN_W'(1);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data = sb[i];
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("sw wr_en", 64'(wr_en), 64'd1);
      chk("sw wr_addr", wr_addr, 64'd0);
      chk("sw wr_data", 64'(wr_data), 64'h91000421);
      chk("sw in_ready_in_write", 64'(in_ready), 64'd0);
      chk("sw done_early", 64'(done), 64'd0);
      chk("sw busy_in_write", 64'(busy), 64'd1);
      @(negedge clk);
      chk("sw done", 64'(done), 64'd1);
      chk("sw busy_fall", 64'(busy), 64'd0);
      chk("sw hold_fall", 64'(cpu_hold), 64'd0);
      chk("sw wr_en_off", 64'(wr_en), 64'd0);
      chk("sw wr_data_hold", 64'(wr_data), 64'h91000421);
      chk("sw nwrites", 64'(wq.size()), 64'd1);

      // Reset mid-load: 2 bytes of a 4-word load, then abort.
      wq.delete();
      @(negedge clk);
      start = 1'b1;
      num_words = LEN_W'(4);
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1;
      in_data = 8'hAA;
      @(negedge clk);
      in_data = 8'hBB;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("mid busy", 64'(busy), 64'd0);
      chk("mid in_ready", 64'(in_ready), 64'd0);
      chk("mid wr_data", 64'(wr_data), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (6) @(negedge clk);
      in_valid = 1'b0;
      chk("mid nwrites", 64'(wq.size()), 64'd0);
      chk("mid busy_after", 64'(busy), 64'd0);
      chk("mid hold_after", 64'(cpu_hold), 64'd0);
      chk("mid done", 64'(done), 64'd0);
      chk("mid error", 64'(error), 64'd0);
      chk("mid in_ready_after", 64'(in_ready), 64'd0);
      chk("mid wr_addr", wr_addr, 64'd0);

      // Table of loads against the reference model.
      for (int k = 0; k < 9; k++) run_load(vecs[k], k);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
